ifu_pc_fetch: RTL
=================

Name: ifu_pc_fetch

Overview:
- Instruction-fetch front end: holds the architectural PC and runs a request/response FSM against instruction memory.
- Delivers each fetched instruction and its PC downstream to decode over a valid/ready handshake.
- Accepts control-flow redirects from execute. The redirect is driven when the branch comparator asserts jump_branch, and also on jal/jalr.
- Sits directly upstream of the decode/execute path that contains the branch comparator.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, PC/instruction width; only 32 supported.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high.
- redirect_valid  in  1  execute requests PC redirect this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address, word aligned.
- imem_resp_valid  in  1  instruction data valid (one response per accepted request, ≥1 cycle later).
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=REQ, kill=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - imem_req_valid=0 during the cycle rst is high; imem_req_addr=pc.
- States: REQ, WAIT, HOLD (2-bit encoding). Internal kill flag.
- REQ:
  - imem_req_valid=1 (when rst=0), addr=pc.
  - Request accepted (valid&ready) -> WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with kill=0: inst<=resp_data, inst_pc<=pc, inst_valid<=1, -> HOLD.
  - On imem_resp_valid with kill=1: discard data, kill<=0, -> REQ.
- HOLD:
  - inst_valid=1; inst/inst_pc held stable until consumed.
  - On inst_valid&inst_ready: inst_valid<=0, pc<=pc+4, -> REQ.
- Fetch latency: an instruction is visible at most 1 cycle after its response; a new request issues the cycle after the consume handshake.
- Redirect has priority over sequential update in every state. pc<=redirect_pc with [1:0]=0.
  - REQ, not accepted: stay REQ; addr shows new pc next cycle. The memory port is declared tolerant of address change before acceptance.
  - REQ, accepted same cycle: -> WAIT, kill<=1 (stale response discarded).
  - WAIT, no response: kill<=1, stay WAIT.
  - WAIT, response same cycle: response dropped, kill<=0, -> REQ.
  - HOLD: inst_valid<=0, -> REQ. If inst_ready coincides, the handshake counts as consumed, but pc takes redirect_pc, not pc+4.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- imem_resp_valid outside WAIT is ignored.
- Reset mid-transaction: all state returns to reset values. A response belonging to a pre-reset request that arrives during REQ is ignored. If it arrives after the new request is accepted, it is accepted as that request's response; the memory is required to flush on rst.
- inst_valid never deasserts without a handshake, except on redirect or rst.

Decomposition:
- Shared package: fetch-state enum (REQ/WAIT/HOLD), RESET_PC default, instruction width constant.
- Single module; no sub-module needed. The PC register and next-PC mux stay inline, and the next-PC mux is a clearly separated always block.

Test Plan:
- Reset release, imem ready always, 1-cycle response of 32'h00000013 -> first request addr 8000_0000; inst_valid with inst_pc=8000_0000; after inst_ready, next addr 8000_0004.
- inst_ready held low 5 cycles in HOLD -> inst/inst_pc stable, no new imem_req_valid; on ready, exactly one pc+4 advance.
- Redirect to 8000_0100 during WAIT, response 3 cycles later -> response discarded, no inst_valid; next request addr 8000_0100.
- Redirect to 8000_0203 in HOLD coinciding with inst_ready -> inst_valid drops; next request addr 8000_0200, not pc+4.
- pc=FFFF_FFFC consumed -> next request addr 0000_0000.
- rst asserted during WAIT, then released -> outputs at reset values; first request addr RESET_PC; a stray imem_resp_valid during REQ produces no inst_valid.

Source files
------------

// File: rtl/ifu_pc_fetch_pkg.sv
// ifu_pc_fetch_pkg
// Shared definitions for the instruction-fetch front end: the fetch FSM
// state type, the default reset PC, the instruction width, and a helper
// that forces an address onto a 4-byte boundary.
package ifu_pc_fetch_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // REQ : request outstanding toward instruction memory
    // WAIT: request accepted, waiting for the response
    // HOLD: instruction presented to decode, waiting for the consume
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [INST_W-1:0] align_word(input logic [INST_W-1:0] addr);
        return {addr[INST_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pc_fetch_if.sv
// ifu_pc_fetch_if
// Bundles every fetch-unit signal except clock and reset:
//   redirect_valid/redirect_pc              : PC redirect from execute
//   imem_req_valid/imem_req_ready/addr      : request channel to instruction memory
//   imem_resp_valid/imem_resp_data          : response channel from instruction memory
//   inst_valid/inst_ready/inst/inst_pc      : instruction handshake toward decode
// The master modport is the fetch unit; the slave modport is its environment
// (execute, instruction memory and decode taken together).
interface ifu_pc_fetch_if;
    import ifu_pc_fetch_pkg::*;

    logic              redirect_valid;
    logic [INST_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [INST_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_ready,
        output imem_req_valid, imem_req_addr,
        output inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_ready,
        input  imem_req_valid, imem_req_addr,
        input  inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/ifu_pc_fetch.sv
// ifu_pc_fetch
// Instruction-fetch front end. Holds the architectural PC, issues one
// request at a time to instruction memory, and hands each returned word
// with its PC to decode over a valid/ready handshake. Redirects from
// execute override the sequential PC in every state; a response belonging
// to a request made before a redirect is discarded via the kill flag.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   fetch_if : ifu_pc_fetch_if.master (redirect, imem request/response, decode)
module ifu_pc_fetch
    import ifu_pc_fetch_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    ifu_pc_fetch_if.master fetch_if
);

    fetch_state_e    state_q, state_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic req_valid;
    logic req_fire;
    logic consume;
    logic redirect;

    assign redirect  = fetch_if.redirect_valid;
    // The request is masked while rst is high so memory never sees a
    // request from a machine that is being reset.
    assign req_valid = (state_q == ST_REQ) && !rst;
    assign req_fire  = req_valid && fetch_if.imem_req_ready;
    assign consume   = (state_q == ST_HOLD) && fetch_if.inst_ready;

    // Next-PC selection: a redirect wins over the sequential advance, even
    // when it coincides with the consume handshake.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = align_word(fetch_if.redirect_pc);
        end else if (consume) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // Fetch FSM next-state logic.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // that no path leaves a value unassigned and infers a latch.
        state_d   = state_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        case (state_q)
            ST_REQ: begin
                if (req_fire) begin
                    state_d = ST_WAIT;
                    // A redirect in the accept cycle makes this request stale.
                    kill_d  = redirect;
                end
            end
            ST_WAIT: begin
                if (fetch_if.imem_resp_valid) begin
                    if (kill_q || redirect) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        inst_d    = fetch_if.imem_resp_data;
                        inst_pc_d = pc_q;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect || fetch_if.inst_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= ST_REQ;
            kill_q    <= 1'b0;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign fetch_if.imem_req_valid = req_valid;
    assign fetch_if.imem_req_addr  = pc_q;
    // The instruction is valid exactly while the FSM sits in HOLD.
    assign fetch_if.inst_valid     = (state_q == ST_HOLD);
    assign fetch_if.inst           = inst_q;
    assign fetch_if.inst_pc        = inst_pc_q;

endmodule
